// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: payload layout, control bubble value and
// skid-stage occupancy encodings.
package pipe_pkg;

    localparam int unsigned NB_REG     = 32;
    localparam int unsigned NB_ADDR    = 5;
    localparam int unsigned NB_CTRL    = 9;
    localparam int unsigned NB_PAYLOAD = 3 * NB_REG + NB_ADDR;

    // Payload layout, LSB first: reg address, write data, ALU result, PC+8.
    localparam int unsigned OFF_ADDR  = 0;
    localparam int unsigned OFF_WDATA = OFF_ADDR + NB_ADDR;
    localparam int unsigned OFF_ALU   = OFF_WDATA + NB_REG;
    localparam int unsigned OFF_PC8   = OFF_ALU + NB_REG;

    localparam logic [NB_CTRL-1:0] CTRL_BUBBLE = '0;

    typedef enum logic [1:0] {
        OccEmpty = 2'd0,
        OccOne   = 2'd1,
        OccFull  = 2'd2
    } occ_e;

    function automatic logic [NB_PAYLOAD-1:0] pack_payload(
        input logic [NB_REG-1:0]  pc8,
        input logic [NB_REG-1:0]  alu,
        input logic [NB_REG-1:0]  wdata,
        input logic [NB_ADDR-1:0] addr
    );
        logic [NB_PAYLOAD-1:0] p;
        p = '0;
        p[OFF_PC8   +: NB_REG]  = pc8;
        p[OFF_ALU   +: NB_REG]  = alu;
        p[OFF_WDATA +: NB_REG]  = wdata;
        p[OFF_ADDR  +: NB_ADDR] = addr;
        return p;
    endfunction

    function automatic logic [NB_REG-1:0] payload_alu(input logic [NB_PAYLOAD-1:0] p);
        return p[OFF_ALU +: NB_REG];
    endfunction

    function automatic logic [NB_ADDR-1:0] payload_addr(input logic [NB_PAYLOAD-1:0] p);
        return p[OFF_ADDR +: NB_ADDR];
    endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int unsigned NB_CNT = 16
) (
    input  logic              i_clk,
    input  logic              i_clear,
    input  logic              i_en,
    output logic [NB_CNT-1:0] o_count
);

    logic [NB_CNT-1:0] count_q;

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            count_q <= '0;
        end else if (i_en && (count_q != '1)) begin
            count_q <= count_q + NB_CNT'(1);
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry
// skid buffer, flush, debug freeze and a saturating stall counter.
module pipe_stage_skid #(
    parameter int unsigned        NB_DATA     = 101,
    parameter int unsigned        NB_CTRL     = 9,
    parameter logic [NB_CTRL-1:0] CTRL_BUBBLE = NB_CTRL'(pipe_pkg::CTRL_BUBBLE),
    parameter int unsigned        SKID        = 1,
    parameter int unsigned        NB_CNT      = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_dunit_clk_en,
    input  logic               i_flush,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_DATA-1:0] i_data,
    input  logic [NB_CTRL-1:0] i_ctrl,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_DATA-1:0] o_data,
    output logic [NB_CTRL-1:0] o_ctrl,
    output logic [1:0]         o_occupancy,
    output logic [NB_CNT-1:0]  o_stall_cnt
);
    import pipe_pkg::*;

    logic               main_valid_q, main_valid_d;
    logic [NB_DATA-1:0] main_data_q, main_data_d;
    logic [NB_CTRL-1:0] main_ctrl_q, main_ctrl_d;
    logic               skid_valid_q, skid_valid_d;
    logic [NB_DATA-1:0] skid_data_q, skid_data_d;
    logic [NB_CTRL-1:0] skid_ctrl_q, skid_ctrl_d;

    occ_e occ;
    logic ready_int;
    logic push;
    logic pop;

    always_comb begin
        occ = OccEmpty;
        if (skid_valid_q) begin
            occ = OccFull;
        end else if (main_valid_q) begin
            occ = OccOne;
        end
    end

    // With the skid buffer, ready depends only on a flop, breaking the i_ready path.
    assign ready_int = (SKID != 0) ? ~skid_valid_q : (~main_valid_q | i_ready);

    assign o_ready     = i_dunit_clk_en & ready_int;
    assign o_valid     = i_dunit_clk_en & main_valid_q;
    assign push        = i_valid & o_ready;
    assign pop         = o_valid & i_ready;
    assign o_data      = main_data_q;
    assign o_ctrl      = o_valid ? main_ctrl_q : CTRL_BUBBLE;
    assign o_occupancy = occ;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;
        if (i_dunit_clk_en) begin
            if (i_flush) begin
                main_valid_d = 1'b0;
                skid_valid_d = 1'b0;
            end else begin
                unique case (occ)
                    OccEmpty: begin
                        if (push) begin
                            main_valid_d = 1'b1;
                            main_data_d  = i_data;
                            main_ctrl_d  = i_ctrl;
                        end
                    end
                    OccOne: begin
                        if (push && pop) begin
                            main_data_d = i_data;
                            main_ctrl_d = i_ctrl;
                        end else if (push && (SKID != 0)) begin
                            skid_valid_d = 1'b1;
                            skid_data_d  = i_data;
                            skid_ctrl_d  = i_ctrl;
                        end else if (pop) begin
                            main_valid_d = 1'b0;
                        end
                    end
                    OccFull: begin
                        if (pop) begin
                            main_data_d  = skid_data_q;
                            main_ctrl_d  = skid_ctrl_q;
                            skid_valid_d = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_ctrl_q  <= CTRL_BUBBLE;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= CTRL_BUBBLE;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
        end
    end

    sat_counter #(
        .NB_CNT (NB_CNT)
    ) u_stall_cnt (
        .i_clk   (i_clk),
        .i_clear (i_reset),
        .i_en    (o_valid & ~i_ready),
        .o_count (o_stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: default, SKID=0 and NB_CNT=4 instances share stimulus.
module tb_pipe_stage_skid;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         flush;
    logic         valid;
    logic         ready_in;
    logic [100:0] data;
    logic [8:0]   ctrl;

    logic         o_ready, o_valid;
    logic [100:0] o_data;
    logic [8:0]   o_ctrl;
    logic [1:0]   o_occ;
    logic [15:0]  o_cnt;

    logic         s0_ready, s0_valid;
    logic [100:0] s0_data;
    logic [8:0]   s0_ctrl;
    logic [1:0]   s0_occ;
    logic [15:0]  s0_cnt;

    logic         c4_ready, c4_valid;
    logic [100:0] c4_data;
    logic [8:0]   c4_ctrl;
    logic [1:0]   c4_occ;
    logic [3:0]   c4_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_skid dut (
        .i_clk (clk), .i_reset (reset), .i_dunit_clk_en (en), .i_flush (flush),
        .i_valid (valid), .o_ready (o_ready), .i_data (data), .i_ctrl (ctrl),
        .o_valid (o_valid), .i_ready (ready_in), .o_data (o_data), .o_ctrl (o_ctrl),
        .o_occupancy (o_occ), .o_stall_cnt (o_cnt)
    );

    pipe_stage_skid #(.SKID (0)) dut_s0 (
        .i_clk (clk), .i_reset (reset), .i_dunit_clk_en (en), .i_flush (flush),
        .i_valid (valid), .o_ready (s0_ready), .i_data (data), .i_ctrl (ctrl),
        .o_valid (s0_valid), .i_ready (ready_in), .o_data (s0_data), .o_ctrl (s0_ctrl),
        .o_occupancy (s0_occ), .o_stall_cnt (s0_cnt)
    );

    pipe_stage_skid #(.NB_CNT (4)) dut_c4 (
        .i_clk (clk), .i_reset (reset), .i_dunit_clk_en (en), .i_flush (flush),
        .i_valid (valid), .o_ready (c4_ready), .i_data (data), .i_ctrl (ctrl),
        .o_valid (c4_valid), .i_ready (ready_in), .o_data (c4_data), .o_ctrl (c4_ctrl),
        .o_occupancy (c4_occ), .o_stall_cnt (c4_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b1; flush = 1'b0; valid = 1'b0; ready_in = 1'b0;
        data = '0; ctrl = '0;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        valid = 1'b1; data = 101'h11; ctrl = 9'h0A1;
        step();
        data = 101'h22; ctrl = 9'h0A2;
        step();
        valid = 1'b0;
        #1;
        checks++;
        if (o_occ !== 2'd2) begin
            errors++; $display("FAIL reset_prefill_occ: got %0d want 2", o_occ);
        end
        reset = 1'b1; en = 1'b0;
        step();
        reset = 1'b0; en = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %0b want 0", o_valid);
        end
        checks++;
        if (o_occ !== 2'd0) begin
            errors++; $display("FAIL reset_occ: got %0d want 0", o_occ);
        end
        checks++;
        if (o_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d want 0", o_cnt);
        end
        checks++;
        if (o_ctrl !== 9'h000) begin
            errors++; $display("FAIL reset_ctrl: got %0h want 0", o_ctrl);
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %0b want 1", o_ready);
        end
        checks++;
        if (o_data !== 101'h0) begin
            errors++; $display("FAIL reset_data: got %0h want 0", o_data);
        end
    endtask

    task automatic test_stream();
        logic [100:0] vals [3];
        logic [8:0]   ctls [3];
        vals[0] = 101'h11; vals[1] = 101'h22; vals[2] = 101'h33;
        ctls[0] = 9'h0A1;  ctls[1] = 9'h0A2;  ctls[2] = 9'h0A3;
        do_reset();
        ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1; data = vals[i]; ctrl = ctls[i];
            step();
            checks++;
            if (o_valid !== 1'b1 || o_data !== vals[i] || o_ctrl !== ctls[i]) begin
                errors++;
                $display("FAIL stream_beat[%0d]: got v=%0b d=%0h c=%0h want v=1 d=%0h c=%0h",
                         i, o_valid, o_data, o_ctrl, vals[i], ctls[i]);
            end
            checks++;
            if (o_occ !== 2'd1) begin
                errors++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, o_occ);
            end
        end
        valid = 1'b0;
        step();
        checks++;
        if (o_valid !== 1'b0 || o_occ !== 2'd0 || o_ctrl !== 9'h000) begin
            errors++;
            $display("FAIL stream_drain: got v=%0b occ=%0d c=%0h want v=0 occ=0 c=0",
                     o_valid, o_occ, o_ctrl);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        valid = 1'b1; data = 101'h11; ctrl = 9'h0A1;
        step();
        data = 101'h22; ctrl = 9'h0A2;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++; $display("FAIL bp_ready_one: got %0b want 1", o_ready);
        end
        step();
        valid = 1'b0;
        step();
        checks++;
        if (o_occ !== 2'd2 || o_ready !== 1'b0 || o_data !== 101'h11) begin
            errors++;
            $display("FAIL bp_full: got occ=%0d rdy=%0b d=%0h want occ=2 rdy=0 d=11",
                     o_occ, o_ready, o_data);
        end
        step();
        checks++;
        if (o_cnt !== 16'd3) begin
            errors++; $display("FAIL bp_cnt_held: got %0d want 3", o_cnt);
        end
        ready_in = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b1 || o_data !== 101'h11 || o_ctrl !== 9'h0A1) begin
            errors++;
            $display("FAIL bp_pop_a: got v=%0b d=%0h c=%0h want v=1 d=11 c=a1",
                     o_valid, o_data, o_ctrl);
        end
        step();
        checks++;
        if (o_valid !== 1'b1 || o_data !== 101'h22 || o_occ !== 2'd1 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_pop_b: got v=%0b d=%0h occ=%0d rdy=%0b want v=1 d=22 occ=1 rdy=1",
                     o_valid, o_data, o_occ, o_ready);
        end
        step();
        checks++;
        if (o_valid !== 1'b0 || o_occ !== 2'd0 || o_cnt !== 16'd3) begin
            errors++;
            $display("FAIL bp_empty: got v=%0b occ=%0d cnt=%0d want v=0 occ=0 cnt=3",
                     o_valid, o_occ, o_cnt);
        end
    endtask

    task automatic test_flush();
        do_reset();
        valid = 1'b1; data = 101'h11; ctrl = 9'h0A1;
        step();
        data = 101'h22; ctrl = 9'h0A2;
        step();
        flush = 1'b1; data = 101'h44; ctrl = 9'h0A4;
        step();
        flush = 1'b0; valid = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_ctrl !== 9'h000 || o_occ !== 2'd0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: got v=%0b c=%0h occ=%0d rdy=%0b want v=0 c=0 occ=0 rdy=1",
                     o_valid, o_ctrl, o_occ, o_ready);
        end
        ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (o_valid !== 1'b0) begin
                errors++; $display("FAIL flush_no_d[%0d]: got v=%0b d=%0h want v=0", i, o_valid, o_data);
            end
        end
    endtask

    task automatic test_freeze();
        do_reset();
        valid = 1'b1; data = 101'h11; ctrl = 9'h0A1;
        step();
        valid = 1'b0;
        step();
        en = 1'b0; valid = 1'b1; data = 101'h55; ctrl = 9'h0A5; flush = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ready_in = (k >= 2);
            #1;
            checks++;
            if (o_valid !== 1'b0 || o_ready !== 1'b0 || o_ctrl !== 9'h000) begin
                errors++;
                $display("FAIL freeze_outs[%0d]: got v=%0b rdy=%0b c=%0h want v=0 rdy=0 c=0",
                         k, o_valid, o_ready, o_ctrl);
            end
            step();
        end
        checks++;
        if (o_occ !== 2'd1 || o_cnt !== 16'd1 || o_data !== 101'h11) begin
            errors++;
            $display("FAIL freeze_hold: got occ=%0d cnt=%0d d=%0h want occ=1 cnt=1 d=11",
                     o_occ, o_cnt, o_data);
        end
        en = 1'b1; flush = 1'b0; valid = 1'b0; ready_in = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b1 || o_data !== 101'h11 || o_ctrl !== 9'h0A1) begin
            errors++;
            $display("FAIL freeze_resume: got v=%0b d=%0h c=%0h want v=1 d=11 c=a1",
                     o_valid, o_data, o_ctrl);
        end
        step();
        checks++;
        if (o_valid !== 1'b0 || o_occ !== 2'd0 || o_cnt !== 16'd1) begin
            errors++;
            $display("FAIL freeze_drain: got v=%0b occ=%0d cnt=%0d want v=0 occ=0 cnt=1",
                     o_valid, o_occ, o_cnt);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        valid = 1'b1; data = 101'h11; ctrl = 9'h0A1;
        step();
        valid = 1'b0;
        for (int i = 0; i < 15; i++) step();
        checks++;
        if (c4_cnt !== 4'd15 || o_cnt !== 16'd15) begin
            errors++; $display("FAIL sat_reach: got c4=%0d c16=%0d want 15 15", c4_cnt, o_cnt);
        end
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (c4_cnt !== 4'd15) begin
            errors++; $display("FAIL sat_hold: got %0d want 15", c4_cnt);
        end
        checks++;
        if (o_cnt !== 16'd20) begin
            errors++; $display("FAIL sat_wide: got %0d want 20", o_cnt);
        end
        ready_in = 1'b1;
        step();
    endtask

    task automatic test_skid0();
        do_reset();
        valid = 1'b1; data = 101'h11; ctrl = 9'h0A1;
        #1;
        checks++;
        if (s0_ready !== 1'b1) begin
            errors++; $display("FAIL s0_ready_empty: got %0b want 1", s0_ready);
        end
        step();
        data = 101'h22; ctrl = 9'h0A2;
        #1;
        checks++;
        if (s0_ready !== 1'b0 || s0_occ !== 2'd1 || s0_data !== 101'h11) begin
            errors++;
            $display("FAIL s0_blocked: got rdy=%0b occ=%0d d=%0h want rdy=0 occ=1 d=11",
                     s0_ready, s0_occ, s0_data);
        end
        ready_in = 1'b1;
        #1;
        checks++;
        if (s0_ready !== 1'b1) begin
            errors++; $display("FAIL s0_ready_follow: got %0b want 1", s0_ready);
        end
        step();
        checks++;
        if (s0_valid !== 1'b1 || s0_data !== 101'h22 || s0_occ !== 2'd1) begin
            errors++;
            $display("FAIL s0_replace: got v=%0b d=%0h occ=%0d want v=1 d=22 occ=1",
                     s0_valid, s0_data, s0_occ);
        end
        ready_in = 1'b0; data = 101'h33; ctrl = 9'h0A3;
        step();
        checks++;
        if (s0_occ !== 2'd1 || s0_data !== 101'h22) begin
            errors++; $display("FAIL s0_no_skid: got occ=%0d d=%0h want occ=1 d=22", s0_occ, s0_data);
        end
        valid = 1'b0; ready_in = 1'b1;
        step();
        checks++;
        if (s0_valid !== 1'b0 || s0_occ !== 2'd0) begin
            errors++; $display("FAIL s0_drain: got v=%0b occ=%0d want v=0 occ=0", s0_valid, s0_occ);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_freeze();
        test_saturate();
        test_skid0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic inter-stage pipeline register that replaces the fixed, enable-only stage registers (ID/EX, EX/M, M/WB).
- Adds a valid/ready handshake, a 2-entry skid buffer so backpressure is registered, flush with bubble insertion, and the debug-unit freeze (i_dunit_clk_en).
- Adds a saturating stall counter that the debug unit can read.
- One instance sits between each pair of pipeline stages. The payload (PC+8, ALU result, write data, register address) is packed into i_data; control bits go on i_ctrl.

Parameters:
- NB_DATA, 101, width of the packed datapath payload (32+32+32+5).
- NB_CTRL, 9, width of the control bundle.
- CTRL_BUBBLE, 0, control value presented whenever the stage holds no valid beat (NB_CTRL bits).
- SKID, 1, 1 = 2-entry skid buffer with registered o_ready; 0 = single register with combinational ready.
- NB_CNT, 16, stall counter width.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_dunit_clk_en  in  1  debug-unit run enable; 0 = freeze
- i_flush  in  1  discard all held beats
- i_valid  in  1  upstream beat valid
- o_ready  out  1  stage can accept a beat
- i_data  in  NB_DATA  upstream payload
- i_ctrl  in  NB_CTRL  upstream control
- o_valid  out  1  downstream beat valid
- i_ready  in  1  downstream accepts
- o_data  out  NB_DATA  payload to next stage
- o_ctrl  out  NB_CTRL  control to next stage; CTRL_BUBBLE when o_valid=0
- o_occupancy  out  2  beats held (0..2)
- o_stall_cnt  out  NB_CNT  cycles with o_valid=1 and i_ready=0 while enabled, saturating

Behaviour:
- Reset (i_reset=1 at posedge) has top priority and is independent of i_dunit_clk_en. Reset values:
  - main and skid valid = 0, so o_valid=0 and o_occupancy=0.
  - o_data = 0, o_ctrl = CTRL_BUBBLE, o_stall_cnt = 0.
  - o_ready = 1 in the first cycle after reset.
- Handshakes:
  - push = i_valid & o_ready.
  - pop = o_valid & i_ready.
  - Both are evaluated only while i_dunit_clk_en=1.
- Freeze (i_dunit_clk_en=0):
  - o_ready and o_valid forced to 0 combinationally.
  - All state, counter and o_data are held.
  - i_flush is ignored.
- SKID=1 states, keyed by occupancy:
  - EMPTY: push -> ONE; the beat appears on o_data/o_ctrl at the next edge (1-cycle latency).
  - ONE: push&pop -> ONE (main replaced); push only -> FULL (beat goes to skid); pop only -> EMPTY.
  - FULL: push is impossible because o_ready=0; pop -> ONE (skid moves to main); otherwise hold.
  - o_ready = ~skid_valid, taken from a flop with no combinational path from i_ready.
- SKID=0: single entry; o_ready = ~o_valid | i_ready; o_occupancy never exceeds 1.
- Flush (i_flush=1, enabled, no reset):
  - All valids cleared next edge; o_ctrl=CTRL_BUBBLE.
  - o_data keeps its last value (don't-care).
  - A push in the same cycle is discarded.
  - A pop in the same cycle still completes: downstream sampled it.
- Ordering: strictly FIFO; beats never duplicated or dropped except by flush.
- o_ctrl is masked to CTRL_BUBBLE whenever o_valid=0, so downstream write enables are never spuriously asserted.
- Stall counter:
  - Increments by 1 on cycles with enable=1 and o_valid=1 and i_ready=0.
  - Saturates at 2^NB_CNT-1.
  - Cleared only by reset.

Decomposition:
- Shared package pipe_pkg:
  - payload field widths: NB_REG=32, NB_ADDR=5, NB_CTRL=9.
  - payload pack/unpack field offsets.
  - CTRL_BUBBLE constant.
  - occupancy encodings EMPTY=0, ONE=1, FULL=2.
- One natural sub-module: sat_counter (parametrised width, enable, synchronous clear) for o_stall_cnt.

Test Plan:
- Reset mid-traffic in FULL, i_dunit_clk_en=0 -> next cycle o_valid=0, o_occupancy=0, o_stall_cnt=0, o_ctrl=0, o_ready=1.
- Stream A=0x11,B=0x22,C=0x33 with i_ready=1 -> each appears 1 cycle after push, in order; o_occupancy stays 1.
- Push A,B with i_ready=0 -> occupancy 2, o_ready=0, o_data=A.
  - Raise i_ready -> A then B popped, in order.
  - o_stall_cnt equals the number of held cycles (e.g. 3).
- FULL state, i_flush=1 with i_valid=1 (D=0x44) -> next cycle o_valid=0, o_ctrl=CTRL_BUBBLE, occupancy 0; D never emitted.
- ONE state holding A, i_dunit_clk_en=0 for 5 cycles with i_valid=1, i_ready=1, i_flush=1:
  - o_valid=0, o_ready=0; occupancy and counter unchanged.
  - Re-enable -> A emitted, flush had no effect.
- NB_CNT=4, hold i_ready=0 for 20 enabled cycles -> o_stall_cnt saturates at 15. Also run the scenarios with SKID=0: o_ready follows i_ready the same cycle, occupancy never exceeds 1.
